load_store_unit: RTL and testbench

//  Sits between the execute stage and data_mem; the only block that drives data_mem.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and small helpers for lane selection and request classification.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [4:0] byte_shift(input logic [1:0] addr_lo);
        return {addr_lo, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic [1:0] addr_lo);
        return {addr_lo[1], 4'b0000};
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Size comes from funct3[1:0], so illegal codes can also report misalignment.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return {addr_lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide data_mem port of the LSU.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic              resp_illegal;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, and
// byte/half merge of new store data into an existing memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        lane_b = rdata[byte_shift(addr_lo) +: 8];
        lane_h = rdata[half_shift(addr_lo) +: 16];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'b0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'b0, lane_h};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                lane_mask = 32'h0000_00ff << byte_shift(addr_lo);
                lane_data = {24'b0, new_data[7:0]} << byte_shift(addr_lo);
            end
            2'b01: begin
                lane_mask = 32'h0000_ffff << half_shift(addr_lo);
                lane_data = {16'b0, new_data[15:0]} << half_shift(addr_lo);
            end
            default: begin
                lane_mask = '1;
                lane_data = new_data;
            end
        endcase

        merged = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of data_mem. Sub-word stores are
// done as read-modify-write since data_mem only has a word write enable.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;

    logic              req_ill;
    logic              req_mis;
    logic [1:0]        req_lo;
    logic [31:0]       load_ext;
    logic [31:0]       store_merged;

    lsu_align u_align (
        .rdata     (bus.mem_rdata),
        .old_word  (merge_q),
        .new_data  (wdata_q),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .load_data (load_ext),
        .merged    (store_merged)
    );

    always_comb begin
        req_ill = ~f3_legal(bus.req_we, bus.req_funct3);
        req_mis = ALIGN_CHECK & f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
        req_lo  = ALIGN_CHECK ? bus.req_addr[1:0]
                              : force_align(bus.req_funct3, bus.req_addr[1:0]);

        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = '0;
        resp_valid_d = 1'b0;
        mis_d        = 1'b0;
        ill_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = {bus.req_addr[ADDR_W-1:2], req_lo};
                    wdata_d  = bus.req_wdata;
                    if (req_ill || req_mis) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        ill_d        = req_ill;
                        mis_d        = req_mis;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d      = load_ext;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else if (funct3_q == F3_W) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    merge_d = bus.mem_rdata;
                    state_d = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            ill_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            mis_q        <= mis_d;
            ill_q        <= ill_d;
        end
    end

    assign bus.req_ready       = (state_q == ST_IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_misaligned = mis_q;
    assign bus.resp_illegal    = ill_q;

    // Write enable is decoded from state but masked by rst so a reset cycle never writes.
    assign bus.mem_we    = ~rst & (((state_q == ST_ACCESS) & we_q & (funct3_q == F3_W)) |
                                   (state_q == ST_RMW_WR));
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = (state_q == ST_RMW_WR) ? store_merged : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural data_mem.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] mem [0:15];
    bit          mem_loaded = 1'b0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[3]     <= 32'hf00f_f00f;
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_count = 0;
    int          last_we_cyc = -1;
    logic [31:0] last_we_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_we === 1'b1) begin
            we_count++;
            last_we_cyc  = cyc;
            last_we_addr = bus.mem_addr;
        end
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'b0, bus.resp_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
                check({e.tag, "_mis"}, {31'b0, bus.resp_misaligned}, {31'b0, e.mis});
                check({e.tag, "_ill"}, {31'b0, bus.resp_illegal}, {31'b0, e.ill});
                check({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Leaves req_valid high after the accepting edge so requests can be chained.
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_mis,
                         input logic exp_ill, input int lat, input bit expect_resp,
                         output int t_acc);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, {31'b0, bus.req_ready}, 32'h1);
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc;
        if (expect_resp) begin
            e.tag   = tag;
            e.rdata = exp_rdata;
            e.mis   = exp_mis;
            e.ill   = exp_ill;
            e.cyc   = t_acc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("drain", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t1;
        int t2;
        int wc;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_misaligned", {31'b0, bus.resp_misaligned}, 32'h0);
        check("rst_illegal", {31'b0, bus.resp_illegal}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_ready", {31'b0, bus.req_ready}, 32'h1);
        rst = 1'b0;

        // Loads with sign/zero extension from the preloaded word
        wc = we_count;
        issue("lb_0c", 1'b0, F3_B, 32'h200c, '0, 32'h0000_000f, 1'b0, 1'b0, 2, 1'b1, t);
        drain();
        check("lb_no_we", we_count, wc);
        issue("lb_0f", 1'b0, F3_B, 32'h200f, '0, 32'hffff_fff0, 1'b0, 1'b0, 2, 1'b1, t);
        drain();
        issue("lbu_0f", 1'b0, F3_BU, 32'h200f, '0, 32'h0000_00f0, 1'b0, 1'b0, 2, 1'b1, t);
        drain();
        issue("lhu_0e", 1'b0, F3_HU, 32'h200e, '0, 32'h0000_f00f, 1'b0, 1'b0, 2, 1'b1, t);
        drain();
        issue("lh_0e", 1'b0, F3_H, 32'h200e, '0, 32'hffff_f00f, 1'b0, 1'b0, 2, 1'b1, t);
        drain();
        check("loads_no_we", we_count, wc);

        // Byte store via read-modify-write
        wc = we_count;
        issue("sb_0d", 1'b1, F3_B, 32'h200d, 32'h1234_56aa, '0, 1'b0, 1'b0, 3, 1'b1, t);
        drain();
        check("sb_we_count", we_count, wc + 1);
        check("sb_we_cycle", last_we_cyc, t + 2);
        check("sb_we_addr", last_we_addr, 32'h200c);
        check("sb_word", mem[3], 32'hf00f_aa0f);
        issue("lw_0c", 1'b0, F3_W, 32'h200c, '0, 32'hf00f_aa0f, 1'b0, 1'b0, 2, 1'b1, t);
        drain();

        // Faults: misaligned, illegal, and both together
        wc = we_count;
        issue("lw_mis", 1'b0, F3_W, 32'h2002, '0, 32'h0, 1'b1, 1'b0, 1, 1'b1, t);
        drain();
        issue("lh_mis", 1'b0, F3_H, 32'h200d, '0, 32'h0, 1'b1, 1'b0, 1, 1'b1, t);
        drain();
        issue("ld_f3_011", 1'b0, 3'b011, 32'h200c, '0, 32'h0, 1'b0, 1'b1, 1, 1'b1, t);
        drain();
        issue("st_f3_100", 1'b1, 3'b100, 32'h200c, 32'hffff_ffff, 32'h0, 1'b0, 1'b1, 1, 1'b1, t);
        drain();
        issue("sw_mis", 1'b1, F3_W, 32'h200e, 32'h5555_5555, 32'h0, 1'b1, 1'b0, 1, 1'b1, t);
        drain();
        issue("ld_f3_110", 1'b0, 3'b110, 32'h2001, '0, 32'h0, 1'b1, 1'b1, 1, 1'b1, t);
        drain();
        check("fault_no_we", we_count, wc);
        check("fault_word", mem[3], 32'hf00f_aa0f);

        // Reset landing in the RMW write cycle of a half store
        wc = we_count;
        issue("sh_rst", 1'b1, F3_H, 32'h200c, 32'h0000_beef, '0, 1'b0, 1'b0, 3, 1'b0, t);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, bus.req_ready}, 32'h1);
        check("post_rst_resp", {31'b0, bus.resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_rmw_we_count", we_count, wc);
        check("rst_rmw_word", mem[3], 32'hf00f_aa0f);

        // Back-to-back with req_valid held high
        wc = we_count;
        issue("sw_b2b", 1'b1, F3_W, 32'h2008, 32'hcafe_f00d, '0, 1'b0, 1'b0, 2, 1'b1, t1);
        issue("lw_b2b", 1'b0, F3_W, 32'h2008, '0, 32'hcafe_f00d, 1'b0, 1'b0, 2, 1'b1, t2);
        drain();
        check("b2b_accept_gap", t2 - t1, 32'd3);
        check("b2b_we_count", we_count, wc + 1);
        check("b2b_word", mem[2], 32'hcafe_f00d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
